// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RISC-V controller: states, opcodes,
// datapath mux codes and the per-state control word.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2, S_LUI
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SLT  = 3'd5;
  localparam logic [2:0] ALU_SLTU = 3'd6;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] alu_control;
  } ctrl_t;

  // Moore control word for a state; alu_ctl is only consumed by EXECR/EXECI.
  function automatic ctrl_t state_ctrl(input state_t s, input logic [2:0] alu_ctl);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write = 1'b1; c.pc_write = 1'b1;
        c.alu_src_a = SRCA_PC; c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALURES;
      end
      S_DECODE:   begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; end
      S_MEMADR:   begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM; end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB:    begin c.result_src = RES_DATA; c.reg_write = 1'b1; end
      S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      S_EXECR: begin
        c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_RD2; c.alu_control = alu_ctl;
      end
      S_EXECI: begin
        c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM; c.alu_control = alu_ctl;
      end
      S_ALUWB:    begin c.result_src = RES_ALUOUT; c.reg_write = 1'b1; end
      S_BRANCH: begin
        c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_RD2; c.alu_control = ALU_SUB;
      end
      S_JAL: begin
        c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR; c.pc_write = 1'b1;
      end
      S_JALR1: begin
        c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM; c.result_src = RES_ALURES;
        c.pc_write = 1'b1;
      end
      S_JALR2: begin
        c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALURES;
        c.reg_write = 1'b1;
      end
      S_LUI:      begin c.result_src = RES_IMM; c.reg_write = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode for R/I-type execute states; purely combinational.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (funct3)
      // op5 separates R-type from I-type: addi never becomes sub.
      3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b100:  alu_control = ALU_XOR;
      3'b110:  alu_control = ALU_OR;
      3'b111:  alu_control = ALU_AND;
      3'b010:  alu_control = ALU_SLT;
      3'b011:  alu_control = ALU_SLTU;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32 main controller: registered Moore control word per state,
// with branch PCWrite resolved combinationally from the ALU flags.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  input  logic       bge,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc
);

  localparam ctrl_t CTRL_FETCH = state_ctrl(S_FETCH, ALU_ADD);

  state_t     state;
  state_t     state_nxt;
  ctrl_t      ctrl;
  logic [2:0] alu_dec;
  logic       taken;

  alu_decoder u_alu_decoder (
    .op5         (op[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (alu_dec)
  );

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXECR;
          OP_ITYPE:          state_nxt = S_EXECI;
          OP_BRANCH:         state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          OP_JALR:           state_nxt = S_JALR1;
          OP_LUI:            state_nxt = S_LUI;
          default:           state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:  state_nxt = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_nxt = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: state_nxt = S_ALUWB;
      S_JALR1:   state_nxt = S_JALR2;
      default:   state_nxt = S_FETCH;
    endcase
  end

  // The control word is loaded for the state being entered, so it lines up
  // with that state's cycle; reset preloads FETCH for the first cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      ctrl  <= CTRL_FETCH;
    end else begin
      state <= state_nxt;
      ctrl  <= state_ctrl(state_nxt, alu_dec);
    end
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = bge;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_STORE:  ImmSrc = IMM_S;
      OP_BRANCH: ImmSrc = IMM_B;
      OP_JAL:    ImmSrc = IMM_J;
      OP_LUI:    ImmSrc = IMM_U;
      default:   ImmSrc = IMM_I;
    endcase
  end

  // Write enables are gated by rst_n so they drop the instant reset asserts.
  assign PCWrite    = rst_n & ((state == S_BRANCH) ? taken : ctrl.pc_write);
  assign IRWrite    = rst_n & ctrl.ir_write;
  assign MemWrite   = rst_n & ctrl.mem_write;
  assign RegWrite   = rst_n & ctrl.reg_write;
  assign AdrSrc     = ctrl.adr_src;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign ResultSrc  = ctrl.result_src;
  assign ALUControl = ctrl.alu_control;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: per-cycle expected control vectors are queued per instruction.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0, lt = 1'b0, bge = 1'b0;
  logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ALUControl, ImmSrc;

  int n_chk  = 0;
  int n_pass = 0;
  logic [13:0] exp_q[$];
  logic [13:0] obs;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .bge(bge),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc,
                ALUSrcA, ALUSrcB, ResultSrc, ALUControl};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // {pcw, irw, mw, rw, adr, srca, srcb, res, aluctl}
  function automatic logic [13:0] ev(input logic pcw, irw, mw, rw, adr,
                                     input logic [1:0] sa, sb, rs, input logic [2:0] ac);
    return {pcw, irw, mw, rw, adr, sa, sb, rs, ac};
  endfunction

  function automatic logic [13:0] v_fetch();
    return ev(1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'd0);
  endfunction
  function automatic logic [13:0] v_decode();
    return ev(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'd0);
  endfunction
  function automatic logic [13:0] v_aluwb();
    return ev(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'd0);
  endfunction

  // Drives one instruction from FETCH; pops and compares one vector per cycle.
  task automatic run(input string tag, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic l, input logic g,
                     input logic [2:0] imm_exp);
    int i;
    op = o; funct3 = f3; funct7b5 = f7; zero = z; lt = l; bge = g;
    i = 0;
    while (exp_q.size() > 0 && i < 16) begin
      #1;
      check($sformatf("%s[%0d]", tag, i), 32'(obs), 32'(exp_q.pop_front()));
      check($sformatf("%s_imm[%0d]", tag, i), 32'(ImmSrc), 32'(imm_exp));
      @(negedge clk);
      i++;
    end
  endtask

  task automatic push_rtype(input logic [2:0] ac);
    exp_q.push_back(v_fetch()); exp_q.push_back(v_decode());
    exp_q.push_back(ev(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, ac));
    exp_q.push_back(v_aluwb());
  endtask

  task automatic push_itype(input logic [2:0] ac);
    exp_q.push_back(v_fetch()); exp_q.push_back(v_decode());
    exp_q.push_back(ev(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, ac));
    exp_q.push_back(v_aluwb());
  endtask

  task automatic push_branch(input logic pcw);
    exp_q.push_back(v_fetch()); exp_q.push_back(v_decode());
    exp_q.push_back(ev(pcw, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'd1));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_enables", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
    rst_n = 1'b1;

    push_rtype(3'd1);
    run("sub", 7'b0110011, 3'b000, 1'b1, 0, 0, 0, 3'b000);

    exp_q.push_back(v_fetch()); exp_q.push_back(v_decode());
    exp_q.push_back(ev(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'd0));
    exp_q.push_back(ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0));
    exp_q.push_back(ev(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 3'd0));
    run("lw", 7'b0000011, 3'b010, 1'b0, 0, 0, 0, 3'b000);

    push_branch(1'b1); run("bne_nz", 7'b1100011, 3'b001, 1'b0, 0, 1, 0, 3'b010);
    push_branch(1'b0); run("bne_z",  7'b1100011, 3'b001, 1'b0, 1, 0, 1, 3'b010);
    push_branch(1'b0); run("br_010", 7'b1100011, 3'b010, 1'b0, 1, 1, 1, 3'b010);
    push_branch(1'b1); run("beq_z",  7'b1100011, 3'b000, 1'b0, 1, 0, 1, 3'b010);
    push_branch(1'b0); run("blt_ge", 7'b1100011, 3'b100, 1'b0, 1, 0, 1, 3'b010);
    push_branch(1'b1); run("bge_ge", 7'b1100011, 3'b101, 1'b0, 0, 0, 1, 3'b010);

    exp_q.push_back(v_fetch()); exp_q.push_back(v_decode());
    exp_q.push_back(ev(1, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 3'd0));
    exp_q.push_back(ev(0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 3'd0));
    run("jalr", 7'b1100111, 3'b000, 1'b0, 0, 0, 0, 3'b000);

    exp_q.push_back(v_fetch()); exp_q.push_back(v_decode());
    run("unk", 7'b1111111, 3'b000, 1'b1, 1, 1, 1, 3'b000);

    push_itype(3'd0); run("addi_f7", 7'b0010011, 3'b000, 1'b1, 0, 0, 0, 3'b000);
    push_itype(3'd4); run("xori",    7'b0010011, 3'b100, 1'b0, 0, 0, 0, 3'b000);
    push_rtype(3'd0); run("add",     7'b0110011, 3'b000, 1'b0, 0, 0, 0, 3'b000);
    push_rtype(3'd5); run("slt",     7'b0110011, 3'b010, 1'b0, 0, 0, 0, 3'b000);
    push_rtype(3'd6); run("sltu",    7'b0110011, 3'b011, 1'b0, 0, 0, 0, 3'b000);
    push_rtype(3'd3); run("or",      7'b0110011, 3'b110, 1'b0, 0, 0, 0, 3'b000);
    push_rtype(3'd2); run("and",     7'b0110011, 3'b111, 1'b0, 0, 0, 0, 3'b000);
    push_rtype(3'd0); run("f3_001",  7'b0110011, 3'b001, 1'b1, 0, 0, 0, 3'b000);

    exp_q.push_back(v_fetch()); exp_q.push_back(v_decode());
    exp_q.push_back(ev(1, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 3'd0));
    exp_q.push_back(v_aluwb());
    run("jal", 7'b1101111, 3'b000, 1'b0, 0, 0, 0, 3'b011);

    exp_q.push_back(v_fetch()); exp_q.push_back(v_decode());
    exp_q.push_back(ev(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b11, 3'd0));
    run("lui", 7'b0110111, 3'b000, 1'b0, 0, 0, 0, 3'b100);

    // sw interrupted by reset while in MEMWRITE.
    exp_q.push_back(v_fetch()); exp_q.push_back(v_decode());
    exp_q.push_back(ev(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'd0));
    run("sw", 7'b0100011, 3'b010, 1'b0, 0, 0, 0, 3'b001);
    #1;
    check("sw_memwrite", 32'(obs), 32'(ev(0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0)));
    rst_n = 1'b0;
    #1;
    check("sw_rst_enables", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
    @(negedge clk);
    check("sw_rst_hold", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
    rst_n = 1'b1;

    push_rtype(3'd1);
    run("post_rst", 7'b0110011, 3'b000, 1'b1, 0, 0, 0, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Clocking/reset: one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 op  input  7  instruction opcode (IR[6:0]).
REQ-005 funct3  input  3  IR[14:12].
REQ-006 funct7b5  input  1  IR[30].
REQ-007 zero, lt, bge  input  1 each  ALU flags: SrcA==SrcB, SrcA<SrcB, SrcA>=SrcB.
REQ-008 PCWrite, IRWrite, MemWrite, RegWrite  output  1 each  write enables.
REQ-009 AdrSrc  output  1  memory address: 0=PC, 1=ALUOut.
REQ-010 ALUSrcA  output  2  00=PC, 01=OldPC, 10=RD1.
REQ-011 ALUSrcB  output  2  00=RD2, 01=ImmExt, 10=constant 4.
REQ-012 ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult, 11=ImmExt.
REQ-013 ALUControl  output  3  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu.
REQ-014 ImmSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U; decoded from op in every state.

Function
REQ-015 State register SHALL hold one of: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR1, JALR2, LUI; state advances once per clk edge.
REQ-016 Outputs SHALL be Moore-decoded from state, except PCWrite in BRANCH; unlisted outputs are 0 or don't-care muxes held at 0.
REQ-017 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10, PCWrite=1 -> DECODE.
REQ-018 DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jal target to ALUOut); next by op: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 -> JAL, 1100111 -> JALR1, 0110111 -> LUI, other -> FETCH (no writes).
REQ-019 MEMADR: ALUSrcA=10, ALUSrcB=01, add -> MEMREAD if op=0000011 else MEMWRITE.
REQ-020 MEMREAD: AdrSrc=1 -> MEMWB; MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
REQ-021 MEMWRITE: AdrSrc=1, MemWrite=1 -> FETCH.
REQ-022 EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl from alu decoder -> ALUWB; EXECI: same with ALUSrcB=01 -> ALUWB.
REQ-023 ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
REQ-024 ALU decode (R/I): funct3 000 -> add, or sub when R-type and funct7b5=1 (I-type never sub); 100 xor, 110 or, 111 and, 010 slt, 011 sltu; others -> add.
REQ-025 BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00; PCWrite = taken, taken = zero (000), ~zero (001), lt (100), bge (101), 0 otherwise -> FETCH.
REQ-026 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB (rd <= OldPC+4).
REQ-027 JALR1: ALUSrcA=10, ALUSrcB=01, add, ResultSrc=10, PCWrite=1 -> JALR2; JALR2: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=10, RegWrite=1 -> FETCH.
REQ-028 LUI: ResultSrc=11, RegWrite=1 -> FETCH.
REQ-029 Latency (cycles incl. FETCH): lw 5; sw, R, I, jal, jalr 4; beq-family, lui 3; unknown opcode 2.

Reset
REQ-030 rst_n low SHALL force state to FETCH asynchronously and hold PCWrite, IRWrite, MemWrite, RegWrite at 0 while low.
REQ-031 First rising edge after rst_n rises SHALL execute FETCH; reset mid-instruction abandons it with no further writes.

Structure
REQ-032 Shared package: state encoding, opcode constants, ALUControl codes, ImmSrc/ResultSrc/ALUSrc codes.
REQ-033 One combinational sub-module alu_decoder (op[5], funct3, funct7b5 -> ALUControl); remaining logic in multicycle_controller.

Verification
REQ-034 Reset release, op=0110011, funct3=000, funct7b5=1 -> FETCH, DECODE, EXECR (ALUControl=1), ALUWB (RegWrite=1), FETCH.
REQ-035 op=0000011 -> 5 cycles; MEMREAD AdrSrc=1; MEMWB ResultSrc=01, RegWrite=1; MemWrite never 1.
REQ-036 op=1100011, funct3=001, zero=0 -> BRANCH PCWrite=1; repeat with zero=1 -> PCWrite=0; funct3=010 -> PCWrite=0.
REQ-037 op=1100111 -> JALR1 PCWrite=1 ResultSrc=10, JALR2 RegWrite=1 ALUSrcA=01 ALUSrcB=10.
REQ-038 op=1111111 -> DECODE then FETCH, no write enable asserted in DECODE.
REQ-039 rst_n dropped during MEMWRITE -> MemWrite 0 immediately; after release, FETCH with IRWrite=1.
